// File: rtl/banner_scroll_ctrl.sv
// banner_scroll_ctrl
// Scrolls a circular 4-character window over a hex message and time-multiplexes
// it onto a 4-digit common-anode seven-segment display (an/seg active-low).
module banner_scroll_ctrl #(
  parameter  int MSG_LEN = 10,
  parameter  int MUX_N   = 16,
  localparam int PW      = $clog2(MSG_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   en,
  input  logic                   dir,
  input  logic                   load,
  input  logic [4*MSG_LEN-1:0]   msg_flat,
  output logic [3:0]             an,
  output logic [7:0]             seg,
  output logic [PW-1:0]          pos
);

  localparam logic [PW-1:0] LAST  = PW'(MSG_LEN - 1);
  localparam logic [PW:0]   LEN_W = (PW+1)'(MSG_LEN);

  logic [4*MSG_LEN-1:0] msg_reg;
  logic [MUX_N-1:0]     refresh;
  logic [1:0]           sel;
  logic [PW:0]          sum;
  logic [PW-1:0]        idx;
  logic [3:0]           nib;

  // gfedcba, active-low
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign sel = refresh[MUX_N-1 -: 2];

  // Character index for the active digit; pos+sel never exceeds 2*MSG_LEN-1,
  // so a single conditional subtract gives the modulo.
  always_comb begin
    sum = {1'b0, pos} + (PW+1)'(sel);
    if (sum >= LEN_W) idx = PW'(sum - LEN_W);
    else              idx = PW'(sum);
  end

  // Nibble select from the latched message
  always_comb begin
    nib = 4'h0;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (idx == PW'(k)) nib = msg_reg[4*k +: 4];
    end
  end

  // Message latch: only a load pulse samples msg_flat
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     msg_reg <= '0;
    else if (load) msg_reg <= msg_flat;
  end

  // Scroll position: load wins over a concurrent tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else if (load) begin
      pos <= '0;
    end else if (tick && en) begin
      if (!dir) pos <= (pos == LAST) ? '0 : pos + 1'b1;
      else      pos <= (pos == '0) ? LAST : pos - 1'b1;
    end
  end

  // Free-running refresh counter; its top two bits pick the digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + 1'b1;
  end

  // Registered display drive, one clock behind sel/pos/msg_reg
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 8'hFF;
    end else begin
      an  <= ~(4'b1000 >> sel);
      seg <= {1'b1, hex7(nib)};
    end
  end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Bench for banner_scroll_ctrl with MUX_N=4, MSG_LEN=10.
module tb_banner_scroll_ctrl;

  localparam int MSG_LEN = 10;
  localparam int MUX_N   = 4;
  localparam logic [39:0] MSG_A = 40'h9876543210;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, en, dir, load;
  logic [39:0] msg_flat;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [3:0]  pos;

  banner_scroll_ctrl #(.MSG_LEN(MSG_LEN), .MUX_N(MUX_N)) dut (
    .clk(clk), .reset(reset), .tick(tick), .en(en), .dir(dir),
    .load(load), .msg_flat(msg_flat), .an(an), .seg(seg), .pos(pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0]  m_ref;
  int          m_pos;
  logic [39:0] m_msg;
  logic [11:0] sb[$];
  logic [6:0]  hex_tab[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    bit ld, tk, e, d;
    int exp_pos;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ref = '0;
    m_pos = 0;
    m_msg = '0;
    sb.delete();
  endtask

  function automatic logic [11:0] model_display();
    int s, i;
    logic [3:0] a, nib;
    s   = int'(m_ref[3:2]);
    i   = (m_pos + s) % MSG_LEN;
    nib = m_msg[i*4 +: 4];
    a   = ~(4'b1000 >> s);
    return {a, 1'b1, hex_tab[nib]};
  endfunction

  task automatic step(input bit l, input bit t, input bit e, input bit d);
    logic [11:0] exp;
    @(negedge clk);
    load = l; tick = t; en = e; dir = d;
    sb.push_back(model_display());
    if (l) begin
      m_msg = msg_flat;
      m_pos = 0;
    end else if (t && e) begin
      if (!d) m_pos = (m_pos == MSG_LEN-1) ? 0 : m_pos + 1;
      else    m_pos = (m_pos == 0) ? MSG_LEN-1 : m_pos - 1;
    end
    m_ref = m_ref + 4'd1;
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check("an_seg", {20'h0, an, seg}, {20'h0, exp});
    check("pos_model", {28'h0, pos}, m_pos);
  endtask

  // One full refresh after a settling step; seg checked per digit shown
  task automatic check_window(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] exp;
    step(0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 0);
      case (an)
        4'b0111: exp = s0;
        4'b1011: exp = s1;
        4'b1101: exp = s2;
        default: exp = s3;
      endcase
      check("window_seg", {24'h0, seg}, {24'h0, exp});
    end
  endtask

  initial begin
    logic [3:0] an_seq[4];
    an_seq[0] = 4'b0111; an_seq[1] = 4'b1011; an_seq[2] = 4'b1101; an_seq[3] = 4'b1110;

    tbl[0]  = '{1, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 1, 0, 1};
    tbl[2]  = '{0, 1, 0, 0, 1};
    tbl[3]  = '{0, 1, 1, 1, 0};
    tbl[4]  = '{0, 1, 1, 1, 9};
    tbl[5]  = '{0, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, 1, 0, 1};
    tbl[7]  = '{0, 1, 1, 0, 2};
    tbl[8]  = '{1, 1, 1, 0, 0};
    tbl[9]  = '{0, 1, 0, 1, 0};
    tbl[10] = '{0, 0, 1, 1, 0};
    tbl[11] = '{0, 1, 1, 1, 9};

    reset = 1'b1; tick = 0; en = 0; dir = 0; load = 0; msg_flat = MSG_A;
    model_reset();

    // 1: reset state, then blank message scanning
    #12;
    check("reset_an",  {28'h0, an},  32'hF);
    check("reset_seg", {24'h0, seg}, 32'hFF);
    check("reset_pos", {28'h0, pos}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 0);
      check("scan_an",  {28'h0, an},  {28'h0, an_seq[k/4]});
      check("scan_seg", {24'h0, seg}, 32'hC0);
    end

    // 2: load, one left tick; msg_flat changes afterwards must not matter
    step(1, 0, 0, 0);
    msg_flat = '1;
    step(0, 1, 1, 0);
    check("pos_after_tick", {28'h0, pos}, 32'd1);
    check_window(8'hF9, 8'hA4, 8'hB0, 8'h99);

    // 3: wrap going left
    for (int k = 0; k < 7; k++) step(0, 1, 1, 0);
    check("pos_8", {28'h0, pos}, 32'd8);
    step(0, 1, 1, 0);
    check("pos_9", {28'h0, pos}, 32'd9);
    check_window(8'h90, 8'hC0, 8'hF9, 8'hA4);
    step(0, 1, 1, 0);
    check("pos_wrap0", {28'h0, pos}, 32'd0);

    // 4: wrap going right
    step(0, 1, 1, 1);
    check("pos_right_wrap", {28'h0, pos}, 32'd9);
    check_window(8'h90, 8'hC0, 8'hF9, 8'hA4);

    // 5: table of load/tick/en/dir combinations
    msg_flat = MSG_A;
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].ld, tbl[i].tk, tbl[i].e, tbl[i].d);
      check($sformatf("tbl_pos_%0d", i), {28'h0, pos}, tbl[i].exp_pos);
    end

    // 6: async reset mid-scroll
    step(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0);
    check("pos_5", {28'h0, pos}, 32'd5);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    check("async_an",  {28'h0, an},  32'hF);
    check("async_seg", {24'h0, seg}, 32'hFF);
    check("async_pos", {28'h0, pos}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    check_window(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    check("pos_after_reset", {28'h0, pos}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
